score_keeper: RTL and testbench

- Game-score controller for the dinosaur runner; sequences the score display block.
- Runs the game state machine (idle/run/pause/over) and counts score from a clock-divided tick.
- Derives the speed level and the obstacle-step strobe, and keeps the high score.
- Drives the 13-bit score bus consumed by the seven-segment/dot-matrix display, alternating score and high score after game over.

---
 rtl/score_keeper.sv | 123 ++++++++++++
 tb/tb_score_keeper.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: dino-runner game FSM with score/level/step generation and score display mux.
// SCORE_HISCORE_EN builds high-score tracking, new_hi and the game-over score/high-score alternation.
module score_keeper #(
    parameter int TICK_DIV   = 25,
    parameter int SCORE_MAX  = 6399,
    parameter int LEVEL_STEP = 100,
    parameter int LEVEL_MAX  = 7,
    parameter int STEP_BASE  = 16,
    parameter int STEP_DEC   = 2,
    parameter int ALT_PERIOD = 64
) (
    input  logic        clk2,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    input  logic        pause,
    output logic [12:0] score_disp,
    output logic [12:0] score,
    output logic [12:0] hi_score,
    output logic [2:0]  level,
    output logic        step,
    output logic        running,
    output logic        game_over,
    output logic        new_hi
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int LW = $clog2(LEVEL_STEP + 1);
    localparam int SW = $clog2(STEP_BASE + 1);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] lvl_cnt;
    logic [SW-1:0] step_cnt, step_per, step_len;
    logic [12:0] score_nx;
    logic tick_w, step_w, lvl_w, score_sat, fresh, adv;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = hit ? OVER : pause ? PAUSED : RUN;
            PAUSED:  state_nx = pause ? PAUSED : RUN;
            OVER:    state_nx = start ? RUN : OVER;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        tick_w    = tick_cnt == TW'(TICK_DIV - 1);
        step_w    = step_cnt == step_per - SW'(1);
        lvl_w     = lvl_cnt == LW'(LEVEL_STEP - 1);
        score_sat = score == 13'(SCORE_MAX);
        score_nx  = score + 13'(tick_w && !score_sat);
        step_len  = SW'(STEP_BASE - int'(level) * STEP_DEC);
        fresh     = (state == IDLE || state == OVER) && start;
        adv       = state == RUN && !hit && !pause;
    end
`ifdef SCORE_HISCORE_EN
    localparam int AW = $clog2(2 * ALT_PERIOD + 1);
    logic [AW-1:0] alt_cnt, alt_nx;
    always_comb alt_nx = (alt_cnt == AW'(2 * ALT_PERIOD - 1)) ? '0 : alt_cnt + 1'b1;
    always_ff @(posedge clk2) begin
        if (reset) begin
            hi_score <= '0;
            new_hi   <= 1'b0;
            alt_cnt  <= '0;
        end else if (fresh) begin
            new_hi <= 1'b0;
        end else if (state == RUN && hit) begin
            hi_score <= (score > hi_score) ? score : hi_score;
            new_hi   <= score > hi_score;
            alt_cnt  <= '0;
        end else if (state == OVER) begin
            alt_cnt <= alt_nx;
        end
    end
`else
    assign hi_score = '0;
    assign new_hi   = 1'b0;
`endif
    always_ff @(posedge clk2) begin
        if (reset) begin
            state      <= IDLE;
            score      <= '0;
            score_disp <= '0;
            level      <= '0;
            tick_cnt   <= '0;
            step_cnt   <= '0;
            lvl_cnt    <= '0;
            step_per   <= SW'(STEP_BASE);
            step       <= 1'b0;
            running    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state     <= state_nx;
            running   <= state_nx == RUN;
            game_over <= state_nx == OVER;
            step      <= adv && step_w;
            if (fresh) begin
                score      <= '0;
                score_disp <= '0;
                level      <= '0;
                tick_cnt   <= '0;
                step_cnt   <= '0;
                lvl_cnt    <= '0;
                step_per   <= SW'(STEP_BASE);
            end else if (adv) begin
                tick_cnt   <= tick_w ? '0 : tick_cnt + 1'b1;
                step_cnt   <= step_w ? '0 : step_cnt + 1'b1;
                score      <= score_nx;
                score_disp <= score_nx;
                // new level's period is only picked up at a step wrap
                if (step_w) step_per <= step_len;
                if (tick_w && !score_sat) begin
                    lvl_cnt <= lvl_w ? '0 : lvl_cnt + 1'b1;
                    if (lvl_w && level != 3'(LEVEL_MAX)) level <= level + 1'b1;
                end
            end
`ifdef SCORE_HISCORE_EN
            else if (state == IDLE) score_disp <= hi_score;
            else if (state == OVER) score_disp <= (alt_nx < AW'(ALT_PERIOD)) ? score : hi_score;
`endif
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper (TICK_DIV=4, SCORE_MAX=20, LEVEL_STEP=8).
// Expectations follow SCORE_HISCORE_EN when it is defined for the build.
module tb_score_keeper;
    logic clk2 = 1'b0, reset = 1'b1, start = 1'b0, hit = 1'b0, pause = 1'b0;
    logic [12:0] score_disp, score, hi_score;
    logic [2:0] level;
    logic step, running, game_over, new_hi;
`ifdef SCORE_HISCORE_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif
    typedef struct {string tag; int sel; int exp;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;

    score_keeper #(.TICK_DIV(4), .SCORE_MAX(20), .LEVEL_STEP(8), .LEVEL_MAX(7),
                   .STEP_BASE(16), .STEP_DEC(2), .ALT_PERIOD(64)) dut (
        .clk2(clk2), .reset(reset), .start(start), .hit(hit), .pause(pause),
        .score_disp(score_disp), .score(score), .hi_score(hi_score), .level(level),
        .step(step), .running(running), .game_over(game_over), .new_hi(new_hi)
    );

    always #5 clk2 = ~clk2;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            0: return int'(score);
            1: return int'(score_disp);
            2: return int'(hi_score);
            3: return int'(level);
            4: return int'(step);
            5: return int'(running);
            6: return int'(game_over);
            default: return int'(new_hi);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        sb.push_back('{tag, sel, exp});
    endtask

    task automatic drain;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk2);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step && n < 100);
    endtask

    task automatic push_zero(input string pre);
        push({pre, "_score"}, 0, 0);
        push({pre, "_disp"}, 1, 0);
        push({pre, "_hi"}, 2, 0);
        push({pre, "_level"}, 3, 0);
        push({pre, "_step"}, 4, 0);
        push({pre, "_running"}, 5, 0);
        push({pre, "_over"}, 6, 0);
        push({pre, "_new_hi"}, 7, 0);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_hit;
        hit = 1'b1;
        cyc();
        hit = 1'b0;
    endtask

    initial begin
        int n, steps;
        run(2);
        reset = 1'b0;
        push_zero("rst");
        drain();
        cyc();
        push("idle_score", 0, 0);
        push("idle_running", 5, 0);
        drain();
        // game 1: normal counting, level-ups, saturation, step period
        pulse_start();
        push("g1_entry_running", 5, 1);
        push("g1_entry_score", 0, 0);
        drain();
        run(40);
        push("g1_score40", 0, 10);
        push("g1_disp40", 1, 10);
        push("g1_level40", 3, 1);
        push("g1_running40", 5, 1);
        push("g1_over40", 6, 0);
        drain();
        run(160);
        push("g1_sat_score", 0, 20);
        push("g1_sat_disp", 1, 20);
        push("g1_sat_level", 3, 2);
        drain();
        wait_step(n);
        wait_step(n);
        check("step_period_l2", n, 12);
        pulse_hit();
        push("g1_over", 6, 1);
        push("g1_over_running", 5, 0);
        push("g1_over_step", 4, 0);
        push("g1_over_score", 0, 20);
        push("g1_hi", 2, HI ? 20 : 0);
        push("g1_new_hi", 7, HI ? 1 : 0);
        push("g1_over_disp", 1, 20);
        drain();
        // game 2: equal high score does not set new_hi
        pulse_start();
        push("g2_new_hi_clr", 7, 0);
        push("g2_score0", 0, 0);
        drain();
        run(100);
        pulse_hit();
        push("g2_score", 0, 20);
        push("g2_hi", 2, HI ? 20 : 0);
        push("g2_new_hi_eq", 7, 0);
        drain();
        // game 3: hit on the tick edge suppresses increment and step pulse
        pulse_start();
        run(31);
        push("g3_pre_score", 0, 7);
        drain();
        pulse_hit();
        push("g3_hit_score", 0, 7);
        push("g3_hit_over", 6, 1);
        push("g3_hit_running", 5, 0);
        push("g3_hit_step", 4, 0);
        push("g3_hit_disp", 1, 7);
        push("g3_hi", 2, HI ? 20 : 0);
        push("g3_new_hi", 7, 0);
        drain();
        run(63);
        push("alt_last_score", 1, 7);
        drain();
        cyc();
        push("alt_first_hi", 1, HI ? 20 : 7);
        drain();
        run(63);
        push("alt_last_hi", 1, HI ? 20 : 7);
        drain();
        cyc();
        push("alt_back_score", 1, 7);
        drain();
        // game 4: pause freezes phase, hit ignored while paused
        pulse_start();
        run(22);
        push("g4_pre_pause", 0, 5);
        drain();
        pause = 1'b1;
        steps = 0;
        for (int i = 0; i < 50; i++) begin
            hit = (i == 25);
            cyc();
            if (step) steps++;
        end
        hit = 1'b0;
        check("pause_steps", steps, 0);
        push("pause_score", 0, 5);
        push("pause_running", 5, 0);
        push("pause_hit_ignored", 6, 0);
        drain();
        pause = 1'b0;
        cyc();
        push("resume_running", 5, 1);
        push("resume_score", 0, 5);
        drain();
        cyc();
        push("resume_phase_hold", 0, 5);
        drain();
        cyc();
        push("resume_phase_inc", 0, 6);
        drain();
        pulse_start();
        push("run_start_ignored", 0, 6);
        push("run_start_running", 5, 1);
        drain();
        run(3);
        push("run_continues", 0, 7);
        drain();
        // reset mid-game returns to idle; start required to count again
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        push_zero("mid_rst");
        drain();
        run(10);
        push("post_rst_score", 0, 0);
        push("post_rst_running", 5, 0);
        drain();
        start = 1'b1;
        hit = 1'b1;
        cyc();
        start = 1'b0;
        hit = 1'b0;
        push("idle_start_hit_running", 5, 1);
        push("idle_start_hit_over", 6, 0);
        drain();
        run(4);
        push("restart_score", 0, 1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
